// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane sizing, error helpers.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of one byte lane.
  localparam int unsigned BYTE_W = 8;

  // Low address bits that must be zero for a word access.
  localparam int unsigned ALIGN_BITS = 2;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Word array with per-lane synchronous write and combinational read; contents are never reset.
module byte_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned LANES      = lane_count(DATA_WIDTH),
  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      addr,
  input  logic [LANES-1:0]      we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Stallable load/store responder: accept one request, wait WAIT_STATES cycles, access, respond.
module data_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned LANES  = lane_count(DATA_WIDTH);
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_WIDTH - ALIGN_BITS;
  localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept_c;
  logic                  access_c;
  logic                  err_c;
  logic [LANES-1:0]      ram_we_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)      state_d = WAIT;
      WAIT:    if (cnt_q == '0)    state_d = RESP;
      RESP:    if (resp_ready)     state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State-decoded outputs and internal strobes.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept_c   = 1'b0;
    access_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = ~rst;
        accept_c  = req_valid;
      end
      WAIT:    access_c   = (cnt_q == '0);
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Misaligned or beyond-array word index; upper bits are compared in full so nothing aliases.
  assign err_c = (addr_q[ALIGN_BITS-1:0] != '0) ||
                 (addr_q[ADDR_WIDTH-1:ALIGN_BITS] >= WIDX_W'(DEPTH_WORDS));

  assign ram_we_c = (access_c && write_q && !err_c) ? wstrb_q : '0;

  byte_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .addr  (addr_q[ALIGN_BITS +: IDX_W]),
    .we    (ram_we_c),
    .wdata (wdata_q),
    .rdata (ram_rdata_c)
  );

  // Capture the request on accept and count down the wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept_c) begin
      cnt_q   <= CNT_W'(WAIT_STATES);
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Response payload, held until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access_c) begin
      err_q   <= err_c;
      rdata_q <= (err_c || write_q) ? '0 : ram_rdata_c;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) against a transaction-level model.
module tb_data_memory_responder;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, req_valid, req_write, resp_ready, req_ready, resp_valid, resp_err;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_wdata [2];
  logic [DW-1:0] resp_rdata [2];
  logic [3:0]    req_wstrb [2];

  int n_checks = 0;
  int n_errors = 0;

  data_memory_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)
  ) dut_ws2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_memory_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)
  ) dut_ws0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got 0x%08h, want 0x%08h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction per instance; the response is due WS+1 edges after accept.
  logic [31:0] mmem [2][DEPTH];
  bit          m_busy [2];
  int          m_due [2];
  bit          m_w [2];
  logic [31:0] m_a [2];
  logic [31:0] m_d [2];
  logic [3:0]  m_s [2];
  logic [31:0] m_rd [2];
  bit          m_err [2];
  int          tcnt = 0;
  bit          exp_rdy, exp_vld;

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  task automatic model_access(input int k);
    int unsigned idx;
    idx = m_a[k] >> 2;
    if ((m_a[k] & 32'h3) != 0 || idx >= DEPTH) begin
      m_err[k] = 1'b1;
      m_rd[k]  = '0;
    end else if (m_w[k]) begin
      for (int i = 0; i < 4; i++)
        if (m_s[k][i]) mmem[k][idx][8*i +: 8] = m_d[k][8*i +: 8];
      m_err[k] = 1'b0;
      m_rd[k]  = '0;
    end else begin
      m_err[k] = 1'b0;
      m_rd[k]  = mmem[k][idx];
    end
  endtask

  // Compare every cycle, then advance the model to what the coming edge must do.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_rdy = !rst[k] && !m_busy[k];
      exp_vld = !rst[k] && m_busy[k] && (tcnt > m_due[k]);
      chk("req_ready", k, 32'(req_ready[k]), 32'(exp_rdy));
      chk("resp_valid", k, 32'(resp_valid[k]), 32'(exp_vld));
      if (rst[k]) begin
        chk("rst_rdata", k, resp_rdata[k], 32'h0);
        chk("rst_err", k, 32'(resp_err[k]), 32'h0);
      end else if (exp_vld) begin
        chk("resp_rdata", k, resp_rdata[k], m_rd[k]);
        chk("resp_err", k, 32'(resp_err[k]), 32'(m_err[k]));
      end
      if (rst[k]) begin
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k] = 1'b1;
          m_due[k]  = tcnt + ws_of(k) + 1;
          m_w[k]    = req_write[k];
          m_a[k]    = req_addr[k];
          m_d[k]    = req_wdata[k];
          m_s[k]    = req_wstrb[k];
        end
      end else if (tcnt == m_due[k]) begin
        model_access(k);
      end else if (tcnt > m_due[k] && resp_ready[k]) begin
        m_busy[k] = 1'b0;
      end
    end
    tcnt++;
  end

  // ---------------- drivers (called #1 after a rising edge) ----------------
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit got = 1'b0;
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_wstrb[k] = s;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = req_ready[k];
      @(posedge clk); #1;
    end
    chk("accept_timeout", k, 32'(got), 32'h1);
    // Scramble the bus after accept; the latched request must not change.
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_wstrb[k] = 4'($urandom);
  endtask

  task automatic wait_resp(input int k, input bit rand_rr, output logic [31:0] rd,
                           output logic e, output int lat);
    bit got = 1'b0;
    lat = -1; rd = 'x; e = 1'bx;
    for (int n = 0; n < 200 && !got; n++) begin
      resp_ready[k] = rand_rr ? 1'($urandom) : 1'b1;
      @(negedge clk);
      if (resp_valid[k] && lat < 0) lat = n;
      if (resp_valid[k] && resp_ready[k]) begin
        rd = resp_rdata[k]; e = resp_err[k]; got = 1'b1;
      end
      @(posedge clk); #1;
    end
    resp_ready[k] = 1'b1;
    chk("resp_timeout", k, 32'(got), 32'h1);
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit rand_rr,
                     output logic [31:0] rd, output logic e, output int lat);
    issue(k, w, a, d, s);
    wait_resp(k, rand_rr, rd, e, lat);
  endtask

  logic [31:0] rd, a;
  logic        e;
  int          lat, acc_n, last;
  bit          got_v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 2'b11; req_valid = '0; req_write = '0; resp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;

    // Fill both arrays so every later load has a defined expectation.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++)
        txn(k, 1'b1, 32'(4*i), $urandom, 4'hF, 1'b1, rd, e, lat);

    // Store-then-load with two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, e, lat);
    chk("st_lat", 0, lat, 32'd3);
    chk("st_err", 0, 32'(e), 32'h0);
    chk("st_rdata", 0, rd, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("ld_lat", 0, lat, 32'd3);
    chk("ld_rdata", 0, rd, 32'hDEADBEEF);
    chk("ld_err", 0, 32'(e), 32'h0);

    // Partial strobe over the previous word.
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, rd, e, lat);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("strb_rdata", 0, rd, 32'hDE22BE44);

    // Backpressure with a competing request held on the bus.
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h14; req_wstrb[0] = 4'h0;
    got_v = 1'b0;
    for (int n = 0; n < 20 && !got_v; n++) begin
      @(negedge clk);
      got_v = resp_valid[0];
      if (!got_v) begin @(posedge clk); #1; end
    end
    chk("bp_resp_timeout", 0, 32'(got_v), 32'h1);
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", 0, 32'(resp_valid[0]), 32'h1);
      chk("bp_rdata", 0, resp_rdata[0], 32'hDE22BE44);
      chk("bp_err", 0, 32'(resp_err[0]), 32'h0);
      chk("bp_ready", 0, 32'(req_ready[0]), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_ready_handshake", 0, 32'(req_ready[0]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_idle", 0, 32'(req_ready[0]), 32'h1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_resp(0, 1'b0, rd, e, lat);
    chk("bp_second_lat", 0, lat, 32'd3);

    // Error accesses leave the array unchanged.
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("mis_err", 0, 32'(e), 32'h1);
    chk("mis_rdata", 0, rd, 32'h0);
    txn(0, 1'b1, 32'(4*DEPTH), 32'h55AA55AA, 4'hF, 1'b0, rd, e, lat);
    chk("oor_err", 0, 32'(e), 32'h1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("err_unchanged", 0, rd, 32'hDE22BE44);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, e, lat);

    // Reset during WAIT of a store: nothing committed.
    txn(0, 1'b1, 32'h20, 32'h01234567, 4'hF, 1'b0, rd, e, lat);
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    rst[0] = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 0, 32'(req_ready[0]), 32'h1);
    chk("rstw_valid", 0, 32'(resp_valid[0]), 32'h0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("rstw_rdata", 0, rd, 32'h01234567);

    // Zero wait states: one-edge latency.
    txn(1, 1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, e, lat);
    chk("ws0_lat", 1, lat, 32'd1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("ws0_rdata", 1, rd, 32'hA5A5_5A5A);

    // Reset while holding a response: the store stays committed.
    resp_ready[1] = 1'b0;
    issue(1, 1'b1, 32'h30, 32'h89ABCDEF, 4'hF);
    @(posedge clk); #1 rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0; resp_ready[1] = 1'b1;
    txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("rstr_rdata", 1, rd, 32'h89ABCDEF);

    // Back-to-back loads with resp_ready high: one accept every 3 cycles.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h10; req_wstrb[1] = 4'h0;
    acc_n = 0; last = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        if (last >= 0) chk("b2b_spacing", 1, n - last, 32'd3);
        last = n;
        acc_n++;
      end
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 1, acc_n, 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle gaps.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 250; t++) begin
        case ($urandom_range(0, 9))
          0: begin
            a = $urandom & 32'hFFFF_FFFC;
            if (a < 32'(4*DEPTH)) a = a + 32'(4*DEPTH);
          end
          1: a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
          default: a = 32'($urandom_range(0, DEPTH-1)) << 2;
        endcase
        txn(k, 1'($urandom), a, $urandom, 4'($urandom), 1'b1, rd, e, lat);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the processor's load/store port. It accepts one word request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs the byte-strobed write or full-word read. It returns the result on a valid/ready response channel, which lets the multi-cycle and pipelined cores run against a realistic, stallable data memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; byte lanes = DATA_WIDTH/8
- DEPTH_WORDS, 1024, number of words stored; word index = req_addr[ADDR_WIDTH-1:2]
- WAIT_STATES, 2, extra cycles between accept and access (0 allowed)

Ports:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE and rst low
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_wstrb  in  DATA_WIDTH/8  store byte enables, bit i -> bits [8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes response
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch write, addr, wdata and wstrb.
  - Load cnt=WAIT_STATES and go to WAIT.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access and go to RESP.
- Access:
  - Error if addr[1:0]!=0 or word index >= DEPTH_WORDS. An error does not touch the array; rdata=0, err=1.
  - Store: write only the lanes enabled in wstrb; rdata=0, err=0.
  - Load: rdata = stored word, err=0.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are registered and held stable until the handshake.
  - On resp_ready, go to IDLE.
  - req_ready stays 0 throughout RESP, including the handshake cycle; there is no request overlap.
- Request fields are ignored outside the accept cycle. Changes to the input bus after accept have no effect.
- Array contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while rst is high.
- Latency: if accept is at edge E0, the access and resp_valid rise both happen at edge E0+WAIT_STATES+1.
- Minimum request spacing is WAIT_STATES+3 cycles, assuming resp_ready is already high.
- Reset mid-operation:
  - rst asserted before the access edge: the store is not committed and the response is dropped.
  - rst asserted in RESP: the response is lost; the array keeps its written data.
- resp_ready held low: stall in RESP indefinitely, outputs constant.
- A req_valid presented while not in IDLE is not accepted; the requester must hold it until it sees req_ready.
- Address arithmetic: the word index uses bits [ADDR_WIDTH-1:2] with no wrap. Indices >= DEPTH_WORDS are errors, never aliased.

## Structure
- Shared package mem_if_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - the lane-count constant
  - the error-condition helper constants
- Sub-module byte_ram:
  - synchronous-write, combinational-read array with per-lane write enables
  - parameterized by DATA_WIDTH and DEPTH_WORDS
  - the FSM/counter lives in data_memory_responder.

## Test plan
- Store-then-load, WAIT_STATES=2:
  - store 0xDEADBEEF to 0x10 with wstrb 4'hF, then load 0x10.
  - Required: resp_rdata=0xDEADBEEF, resp_err=0, and resp_valid exactly 3 edges after each accept.
- Partial strobe:
  - over 0xDEADBEEF, store 0x11223344 to 0x10 with wstrb 4'b0101.
  - Required: a load of 0x10 returns 0xDE22BE44.
- Backpressure:
  - hold resp_ready low for 5 cycles after resp_valid while driving a second req_valid.
  - Required: resp_valid, resp_rdata and resp_err stay constant, req_ready stays 0, and the second request is accepted only after return to IDLE.
- Errors:
  - a load from 0x13 returns err=1, rdata=0.
  - a store to 4*DEPTH_WORDS returns err=1.
  - in both cases, later loads show memory unchanged.
- Reset mid-write:
  - assert rst during WAIT of a store of 0xCAFEF00D to 0x20.
  - Required: after release, req_ready=1 and resp_valid=0; a load of 0x20 returns the previous value.
- WAIT_STATES=0:
  - Required: resp_valid 1 edge after accept.
  - Required: back-to-back transactions with resp_ready tied high complete every 3 cycles.
